// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter (and the future receiver).
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  localparam logic        UART_IDLE_LEVEL    = 1'b1;
  localparam logic        UART_START_LEVEL   = 1'b0;
  localparam int unsigned UART_MAX_DATA_BITS = 8;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                       input logic                          odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_edge_sync.sv
// Three-flop synchroniser with rising-edge detector; tick is one clk wide per rising edge of sig_i.
`timescale 1ns/1ps
module uart_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic tick_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = sig_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // s1/s2 resolve metastability; s3 only delays s2 for the edge compare.
  assign tick_o = s2_q & ~s3_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter paced by a sampled baud clock: start, DATA_BITS LSB-first, optional parity, stop.
// Parity bit is built in only when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);
  localparam logic       LastStop = 1'(STOP_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  tick;
  logic                  accept;

  uart_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (baud_clk),
    .tick_o (tick)
  );

  assign tx_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign accept   = tx_valid & tx_ready;
  assign tx       = tx_q;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (accept) begin
      parity_d = calc_parity(UART_MAX_DATA_BITS'(tx_data), PARITY_ODD[0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    unique case (state_q)
      StIdle: begin
        // A tick coinciding with accept is deliberately not seen by ARM.
        if (accept) begin
          state_d = StArm;
          shift_d = tx_data;
        end
      end
      StArm: begin
        if (tick) state_d = StStart;
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
            state_d    = StParity;
`else
            state_d    = StStop;
`endif
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (stop_cnt_q == LastStop) begin
            state_d = StIdle;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the next state so tx lands on the same edge as the transition.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      StStart:  tx_d = UART_START_LEVEL;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default:  tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= UART_IDLE_LEVEL;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule
